prbs_gen_mw: RTL and testbench

//  Multi-width, multi-polynomial PRBS source for the link BER test path. Emits DATA_W

---
 rtl/prbs_gen_mw.sv | 149 ++++++++++++++
 tb/tb_prbs_gen_mw.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_gen_mw.sv
// prbs_gen_mw: multi-width, multi-polynomial PRBS word source for the link BER test path.
// Latency: one clk from bit_tick to valid; the reference buffer is written in the same cycle as valid.
// Backpressure: none. Each bit_tick in RUN yields exactly one word; ticks outside RUN are ignored.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start / stop                 1-clk pulses. start latches the config and reseeds. stop aborts the run.
//   bit_tick                     1-clk pulse that requests one DATA_W-bit word
//   prbs_sel, burst_len, invert  run configuration, latched on start
//   err_inj                      1-clk pulse that flips the LSB of the next output word
//   prbs_data, valid, done       output word, its strobe, and end-of-finite-run marker
//   busy, word_cnt               run status and words emitted since start
//   ref_we, ref_waddr, ref_wdata clean-word writes into the RX reference buffer
module prbs_gen_mw #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 32,
  parameter int REF_N  = 1024,
  parameter int REF_AW = $clog2(REF_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              bit_tick,
  input  logic [2:0]        prbs_sel,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              invert,
  input  logic              err_inj,
  output logic [DATA_W-1:0] prbs_data,
  output logic              valid,
  output logic              done,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              ref_we,
  output logic [REF_AW-1:0] ref_waddr,
  output logic [DATA_W-1:0] ref_wdata
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] len_q;
  logic             inv_q;
  logic [30:0]      lfsr_q;
  logic             err_arm_q;
  logic             ref_full_q;

  // Polynomial selection. The LFSR register is always 31 bits wide and a
  // mask keeps only the low N bits, so shorter polynomials share the storage.
  logic [4:0]  n_m1;
  logic [4:0]  t_m1;
  logic [30:0] mask;

  always_comb begin
    n_m1 = 5'd30;
    t_m1 = 5'd27;
    mask = 31'h7FFF_FFFF;
    case (sel_q)
      3'd0: begin n_m1 = 5'd6;  t_m1 = 5'd5;  mask = 31'h0000_007F; end
      3'd1: begin n_m1 = 5'd8;  t_m1 = 5'd4;  mask = 31'h0000_01FF; end
      3'd2: begin n_m1 = 5'd14; t_m1 = 5'd13; mask = 31'h0000_7FFF; end
      3'd3: begin n_m1 = 5'd22; t_m1 = 5'd17; mask = 31'h007F_FFFF; end
      default: ;
    endcase
  end

  // Unrolled DATA_W steps. The first bit shifted out lands in the MSB of the word.
  logic [30:0]       lfsr_nx;
  logic [DATA_W-1:0] clean_word;

  always_comb begin
    lfsr_nx    = lfsr_q;
    clean_word = '0;
    for (int k = 0; k < DATA_W; k++) begin
      clean_word[DATA_W-1-k] = lfsr_nx[n_m1];
      lfsr_nx = ((lfsr_nx << 1) | {30'd0, lfsr_nx[n_m1] ^ lfsr_nx[t_m1]}) & mask;
    end
  end

  logic [DATA_W-1:0] ref_word;
  logic [DATA_W-1:0] err_mask;
  logic              last_word;
  logic              run;

  assign run       = (state_q == S_RUN);
  assign ref_word  = clean_word ^ {DATA_W{inv_q}};
  // An err_inj that arrives together with a tick applies to that same word.
  assign err_mask  = DATA_W'(err_arm_q | err_inj);
  assign last_word = (len_q != '0) && (word_cnt == len_q - CNT_W'(1));
  assign busy      = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      len_q      <= '0;
      inv_q      <= 1'b0;
      lfsr_q     <= '1;
      err_arm_q  <= 1'b0;
      ref_full_q <= 1'b0;
      prbs_data  <= '0;
      valid      <= 1'b0;
      done       <= 1'b0;
      word_cnt   <= '0;
      ref_we     <= 1'b0;
      ref_waddr  <= '0;
      ref_wdata  <= '0;
    end else begin
      valid  <= 1'b0;
      done   <= 1'b0;
      ref_we <= 1'b0;
      if (start) begin
        // start takes priority over stop and tick, and it also restarts a run in progress.
        state_q    <= S_RUN;
        sel_q      <= prbs_sel;
        len_q      <= burst_len;
        inv_q      <= invert;
        lfsr_q     <= '1;
        word_cnt   <= '0;
        ref_full_q <= 1'b0;
        err_arm_q  <= 1'b0;
      end else if (run && stop) begin
        state_q   <= S_IDLE;
        err_arm_q <= 1'b0;
      end else if (run && bit_tick) begin
        lfsr_q    <= lfsr_nx;
        prbs_data <= ref_word ^ err_mask;
        valid     <= 1'b1;
        ref_we    <= !ref_full_q;
        ref_waddr <= word_cnt[REF_AW-1:0];
        ref_wdata <= ref_word;
        word_cnt  <= word_cnt + CNT_W'(1);
        err_arm_q <= 1'b0;
        // Once set, ref_full stays latched so that a word_cnt wrap cannot overwrite the buffer.
        if (word_cnt == CNT_W'(REF_N - 1))
          ref_full_q <= 1'b1;
        if (last_word) begin
          done    <= 1'b1;
          state_q <= S_IDLE;
        end
      end else if (run && err_inj) begin
        err_arm_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_gen_mw.sv
module tb_prbs_gen_mw;
  localparam int DW = 8;
  localparam int CW = 32;
  localparam int RN = 16;
  localparam int RA = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, bit_tick = 1'b0, invert = 1'b0, err_inj = 1'b0;
  logic [2:0]    prbs_sel = '0;
  logic [CW-1:0] burst_len = '0;
  logic [DW-1:0] prbs_data;
  logic          valid, done, busy;
  logic [CW-1:0] word_cnt;
  logic          ref_we;
  logic [RA-1:0] ref_waddr;
  logic [DW-1:0] ref_wdata;

  prbs_gen_mw #(.DATA_W(DW), .CNT_W(CW), .REF_N(RN), .REF_AW(RA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .bit_tick(bit_tick),
    .prbs_sel(prbs_sel), .burst_len(burst_len), .invert(invert), .err_inj(err_inj),
    .prbs_data(prbs_data), .valid(valid), .done(done), .busy(busy), .word_cnt(word_cnt),
    .ref_we(ref_we), .ref_waddr(ref_waddr), .ref_wdata(ref_wdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard entry: everything expected alongside one valid word.
  typedef struct packed {
    logic [DW-1:0] data;
    logic          done;
    logic          we;
    logic [RA-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;
  exp_t sbq[$];

  // Reference model: a Fibonacci bit sequence with s[m] = s[m-N] ^ s[m-T],
  // seeded with N ones, consumed in order (first bit -> MSB).
  bit          seq[$];
  int          m_n, m_t, pos;
  bit          m_run, m_inv, m_arm;
  int unsigned m_cnt, m_len;

  function automatic bit get_bit(int m);
    while (seq.size() <= m) begin
      int j = seq.size();
      seq.push_back(seq[j-m_n] ^ seq[j-m_t]);
    end
    return seq[m];
  endfunction

  task automatic model_start();
    case (prbs_sel)
      3'd0: begin m_n = 7;  m_t = 6;  end
      3'd1: begin m_n = 9;  m_t = 5;  end
      3'd2: begin m_n = 15; m_t = 14; end
      3'd3: begin m_n = 23; m_t = 18; end
      default: begin m_n = 31; m_t = 28; end
    endcase
    seq = {};
    for (int i = 0; i < m_n; i++) seq.push_back(1'b1);
    pos   = 0;
    m_run = 1;
    m_cnt = 0;
    m_len = burst_len;
    m_inv = invert;
    m_arm = 0;
  endtask

  // One clock of stimulus. The model predicts the effect of this cycle, then
  // busy and word_cnt are checked just after the edge.
  task automatic step(input bit st, input bit sp, input bit tk, input bit ei);
    exp_t e;
    logic [DW-1:0] w;
    start = st; stop = sp; bit_tick = tk; err_inj = ei;
    if (st) begin
      model_start();
    end else if (sp && m_run) begin
      m_run = 0;
      m_arm = 0;
    end else if (tk && m_run) begin
      w = '0;
      for (int k = 0; k < DW; k++) begin
        w[DW-1-k] = get_bit(pos);
        pos++;
      end
      w       = w ^ {DW{m_inv}};
      e.wdata = w;
      e.data  = w ^ ((m_arm || ei) ? DW'(1) : DW'(0));
      e.done  = (m_len != 0) && (m_cnt == m_len - 1);
      e.we    = (m_cnt < RN);
      e.addr  = RA'(m_cnt % RN);
      sbq.push_back(e);
      m_cnt++;
      m_arm = 0;
      if (e.done) m_run = 0;
    end else if (ei && m_run) begin
      m_arm = 1;
    end
    @(posedge clk); #1;
    start = 0; stop = 0; bit_tick = 0; err_inj = 0;
    chk("busy", busy, m_run);
    chk("word_cnt", word_cnt, m_cnt);
  endtask

  // Monitor: pops the scoreboard for every valid word.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("prbs_data", prbs_data, e.data);
          chk("done", done, e.done);
          chk("ref_we", ref_we, e.we);
          if (e.we) begin
            chk("ref_waddr", ref_waddr, e.addr);
            chk("ref_wdata", ref_wdata, e.wdata);
          end
        end
      end else begin
        chk("strobe_without_valid", {done, ref_we}, 0);
      end
    end
  end

  bit r_st, r_sp, r_tk, r_ei;

  initial begin
    m_run = 0; m_cnt = 0; m_n = 7; m_t = 6; pos = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", prbs_data, 0);
    chk("rst_flags", {valid, done, busy, ref_we}, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_ref", {ref_waddr, ref_wdata}, 0);
    rst_n = 1;

    // PRBS7, two words, done on the second.
    prbs_sel = 0; burst_len = 2; invert = 0;
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("t1_word0", prbs_data, 8'hFE);
    chk("t1_done0", done, 0);
    step(0, 0, 1, 0);
    chk("t1_word1", prbs_data, 8'h04);
    chk("t1_done1", done, 1);
    step(0, 0, 1, 0);                   // tick after done is ignored

    // Inverted output and reference.
    invert = 1; burst_len = 1;
    step(1, 0, 1, 0);                   // tick in start cycle is ignored
    step(0, 0, 1, 0);
    chk("t3_word0", prbs_data, 8'h01);
    chk("t3_ref0", ref_wdata, 8'h01);

    // Error injection on word 2 only, plus one armed without a tick.
    invert = 0; burst_len = 6;
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);                   // err_inj in IDLE dropped

    // Reference buffer fills after RN words.
    prbs_sel = 2; burst_len = 20;
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0);

    // Continuous run, stop with a tick and a pending error.
    prbs_sel = 0; burst_len = 0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 1, 1, 0);
    chk("t6_busy_after_stop", busy, 0);
    step(0, 0, 1, 0);

    // start and stop together: the run restarts from the seed.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("t6_restart_word0", prbs_data, 8'hFE);

    // Reset mid-run.
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    rst_n = 0;
    m_run = 0; m_cnt = 0;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt", word_cnt, 0);
    rst_n = 1;
    step(0, 0, 1, 0);

    // Randomized runs.
    for (int r = 0; r < 40; r++) begin
      prbs_sel  = 3'($urandom_range(0, 7));
      invert    = 1'($urandom_range(0, 1));
      burst_len = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 24));
      step(1, 0, 0, 0);
      for (int c = 0; c < 80 && m_run; c++) begin
        r_tk = 1'($urandom_range(0, 1));
        r_ei = ($urandom_range(0, 9) == 0);
        r_sp = ($urandom_range(0, 49) == 0);
        r_st = ($urandom_range(0, 99) == 0);
        step(r_st, r_sp, r_tk, r_ei);
      end
      if (m_run) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
    end

    step(0, 0, 0, 0);
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
